// File: rtl/rs_pkg.sv
// Shared reservation-station / FU definitions.
// Holds the PRF/ROB/FU-select widths, the FU select encoding, the zero
// register tag, the RS entry payload struct and the dispatch ready helper.
package rs_pkg;

    localparam int unsigned PRF_IDX_W = 6;
    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned FU_SEL_W  = 3;

    localparam logic [PRF_IDX_W-1:0] ZERO_REG = PRF_IDX_W'(0);

    typedef enum logic [FU_SEL_W-1:0] {
        FU_SEL_NONE  = 3'd0,
        FU_SEL_ALU   = 3'd1,
        FU_SEL_LOAD  = 3'd2,
        FU_SEL_STORE = 3'd3,
        FU_SEL_MULT  = 3'd4,
        FU_SEL_BR    = 3'd5
    } fu_sel_e;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] opa_tag;
        logic [PRF_IDX_W-1:0] opb_tag;
        logic                 opa_rdy;
        logic                 opb_rdy;
        logic [PRF_IDX_W-1:0] dest_tag;
        logic [31:0]          ir;
        fu_sel_e              sel;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [63:0]          npc;
    } rs_entry_t;

    // Operand readiness as captured at dispatch: already ready, the zero
    // register, or produced by the CDB broadcast in the same cycle.
    function automatic logic op_ready(input logic [PRF_IDX_W-1:0] tag,
                                      input logic                 rdy,
                                      input logic                 cdb_vld,
                                      input logic [PRF_IDX_W-1:0] cdb_tag);
        return rdy || (tag == ZERO_REG) || (cdb_vld && (tag == cdb_tag));
    endfunction

endpackage

// File: rtl/rs_entry.sv
// Single reservation-station entry: storage, CDB wakeup and eligibility.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            squash (branch recovery)
//   load, pkt      allocate this entry with the dispatch packet
//   issue          entry selected this cycle; free it
//   alu_block      ALU/LOAD/STORE may not issue this cycle
//   cdb_vld/tag    CDB broadcast for wakeup
//   valid, data    registered entry state
//   eligible_c     combinational: entry may be selected this cycle
module rs_entry
    import rs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  rs_entry_t            pkt,
    input  logic                 issue,
    input  logic                 alu_block,
    input  logic                 cdb_vld,
    input  logic [PRF_IDX_W-1:0] cdb_tag,
    output logic                 valid,
    output rs_entry_t            data,
    output logic                 eligible_c
);

    // Entry state; load and issue never coincide (load targets an invalid entry).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr || issue) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= pkt;
        end else if (valid && cdb_vld) begin
            if (data.opa_tag == cdb_tag) data.opa_rdy <= 1'b1;
            if (data.opb_tag == cdb_tag) data.opb_rdy <= 1'b1;
        end
    end

    // Eligibility; integer-pipe ops yield the slot a multiply will complete in.
    always_comb begin
        eligible_c = valid && data.opa_rdy && data.opb_rdy && (data.sel != FU_SEL_NONE);
        if (alu_block && (data.sel inside {FU_SEL_ALU, FU_SEL_LOAD, FU_SEL_STORE}))
            eligible_c = 1'b0;
    end

endmodule

// File: rtl/rs.sv
// Reservation station: allocates dispatched ops into the lowest free entry,
// wakes operands from the CDB, and issues one eligible op per cycle (lowest
// index first) into a registered packet for PRF read / fu_main.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id2rs_*_i           dispatch packet
//   cdb_vld_i/cdb_tag_i registered FU broadcast
//   br_recovery_i       squash all entries
//   rs_full_o           combinational: no free entry
//   rs2fu_*_o           registered issue packet
module rs
    import rs_pkg::*;
#(
    parameter int unsigned RS_NUM   = 8,
    parameter int unsigned MULT_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id2rs_vld_i,
    input  logic [PRF_IDX_W-1:0] id2rs_opa_tag_i,
    input  logic [PRF_IDX_W-1:0] id2rs_opb_tag_i,
    input  logic                 id2rs_opa_rdy_i,
    input  logic                 id2rs_opb_rdy_i,
    input  logic [PRF_IDX_W-1:0] id2rs_dest_tag_i,
    input  logic [31:0]          id2rs_IR_i,
    input  logic [FU_SEL_W-1:0]  id2rs_sel_i,
    input  logic [ROB_IDX_W-1:0] id2rs_rob_idx_i,
    input  logic [63:0]          id2rs_NPC_i,
    input  logic                 cdb_vld_i,
    input  logic [PRF_IDX_W-1:0] cdb_tag_i,
    input  logic                 br_recovery_i,
    output logic                 rs_full_o,
    output logic                 rs2fu_vld_o,
    output logic [PRF_IDX_W-1:0] rs2fu_opa_tag_o,
    output logic [PRF_IDX_W-1:0] rs2fu_opb_tag_o,
    output logic [PRF_IDX_W-1:0] rs2fu_dest_tag_o,
    output logic [31:0]          rs2fu_IR_o,
    output logic [FU_SEL_W-1:0]  rs2fu_sel_o,
    output logic [ROB_IDX_W-1:0] rs2fu_rob_idx_o,
    output logic [63:0]          rs2fu_NPC_o
);

    localparam int unsigned IDX_W = (RS_NUM > 1) ? $clog2(RS_NUM) : 1;

    logic [RS_NUM-1:0] valid;
    logic [RS_NUM-1:0] eligible;
    logic [RS_NUM-1:0] load;
    logic [RS_NUM-1:0] issue;
    rs_entry_t         entry_q [RS_NUM];
    rs_entry_t         disp_pkt;
    rs_entry_t         sel_pkt;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              alloc;
    logic              sel_go;
    logic              mult_sel;
    logic              alu_block;

    // Bit k set: a multiply was selected k+1 cycles ago.
    logic [MULT_LAT-1:0] mult_sr;

    assign rs_full_o = &valid;

    // Dispatch packet with ready bits merged from zero reg and same-cycle CDB.
    always_comb begin
        disp_pkt          = '0;
        disp_pkt.opa_tag  = id2rs_opa_tag_i;
        disp_pkt.opb_tag  = id2rs_opb_tag_i;
        disp_pkt.opa_rdy  = op_ready(id2rs_opa_tag_i, id2rs_opa_rdy_i, cdb_vld_i, cdb_tag_i);
        disp_pkt.opb_rdy  = op_ready(id2rs_opb_tag_i, id2rs_opb_rdy_i, cdb_vld_i, cdb_tag_i);
        disp_pkt.dest_tag = id2rs_dest_tag_i;
        disp_pkt.ir       = id2rs_IR_i;
        disp_pkt.sel      = fu_sel_e'(id2rs_sel_i);
        disp_pkt.rob_idx  = id2rs_rob_idx_i;
        disp_pkt.npc      = id2rs_NPC_i;
    end

    // Lowest-index free entry.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < RS_NUM; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index eligible entry.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < RS_NUM; i++) begin
            if (eligible[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc     = id2rs_vld_i && free_found && !br_recovery_i;
    assign sel_go    = sel_found && !br_recovery_i;
    assign sel_pkt   = entry_q[sel_idx];
    assign mult_sel  = sel_go && (sel_pkt.sel == FU_SEL_MULT);
    // The multiply selected MULT_LAT-1 cycles ago finishes with an ALU op picked now.
    assign alu_block = mult_sr[MULT_LAT-2];

    for (genvar i = 0; i < RS_NUM; i++) begin : g_entry
        assign load[i]  = alloc  && (free_idx == IDX_W'(i));
        assign issue[i] = sel_go && (sel_idx  == IDX_W'(i));

        rs_entry u_entry (
            .clk        (clk),
            .rst        (rst),
            .clr        (br_recovery_i),
            .load       (load[i]),
            .pkt        (disp_pkt),
            .issue      (issue[i]),
            .alu_block  (alu_block),
            .cdb_vld    (cdb_vld_i),
            .cdb_tag    (cdb_tag_i),
            .valid      (valid[i]),
            .data       (entry_q[i]),
            .eligible_c (eligible[i])
        );
    end

    // Multiply history keeps shifting through branch recovery.
    always_ff @(posedge clk) begin
        if (rst) mult_sr <= '0;
        else     mult_sr <= (mult_sr << 1) | MULT_LAT'(mult_sel);
    end

    // Registered issue packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs2fu_vld_o      <= 1'b0;
            rs2fu_opa_tag_o  <= ZERO_REG;
            rs2fu_opb_tag_o  <= ZERO_REG;
            rs2fu_dest_tag_o <= ZERO_REG;
            rs2fu_IR_o       <= '0;
            rs2fu_sel_o      <= FU_SEL_NONE;
            rs2fu_rob_idx_o  <= '0;
            rs2fu_NPC_o      <= '0;
        end else if (sel_go) begin
            rs2fu_vld_o      <= 1'b1;
            rs2fu_opa_tag_o  <= sel_pkt.opa_tag;
            rs2fu_opb_tag_o  <= sel_pkt.opb_tag;
            rs2fu_dest_tag_o <= sel_pkt.dest_tag;
            rs2fu_IR_o       <= sel_pkt.ir;
            rs2fu_sel_o      <= sel_pkt.sel;
            rs2fu_rob_idx_o  <= sel_pkt.rob_idx;
            rs2fu_NPC_o      <= sel_pkt.npc;
        end else begin
            rs2fu_vld_o      <= 1'b0;
            rs2fu_sel_o      <= FU_SEL_NONE;
        end
    end

endmodule

// File: tb/tb_rs.sv
// Directed self-checking bench for rs: a table of single-op dispatch vectors
// plus hand-written multi-cycle sequences (wakeup, full, collision, squash, reset).
module tb_rs;
    import rs_pkg::*;

    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned NV       = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id2rs_vld;
    logic [PRF_IDX_W-1:0] opa_tag, opb_tag, dest_tag;
    logic                 opa_rdy, opb_rdy;
    logic [31:0]          ir;
    logic [FU_SEL_W-1:0]  sel;
    logic [ROB_IDX_W-1:0] rob;
    logic [63:0]          npc;
    logic                 cdb_vld;
    logic [PRF_IDX_W-1:0] cdb_tag;
    logic                 br;

    logic                 full, vld;
    logic [PRF_IDX_W-1:0] o_opa, o_opb, o_dest;
    logic [31:0]          o_ir;
    logic [FU_SEL_W-1:0]  o_sel;
    logic [ROB_IDX_W-1:0] o_rob;
    logic [63:0]          o_npc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        fu_sel_e              sel;
        logic [PRF_IDX_W-1:0] opa;
        logic [PRF_IDX_W-1:0] opb;
        logic                 ardy;
        logic                 brdy;
        logic [PRF_IDX_W-1:0] dest;
        logic                 cvld;
        logic [PRF_IDX_W-1:0] ctag;
        logic                 exp_vld;
        fu_sel_e              exp_sel;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    rs #(.RS_NUM(8), .MULT_LAT(MULT_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .id2rs_vld_i      (id2rs_vld),
        .id2rs_opa_tag_i  (opa_tag),
        .id2rs_opb_tag_i  (opb_tag),
        .id2rs_opa_rdy_i  (opa_rdy),
        .id2rs_opb_rdy_i  (opb_rdy),
        .id2rs_dest_tag_i (dest_tag),
        .id2rs_IR_i       (ir),
        .id2rs_sel_i      (sel),
        .id2rs_rob_idx_i  (rob),
        .id2rs_NPC_i      (npc),
        .cdb_vld_i        (cdb_vld),
        .cdb_tag_i        (cdb_tag),
        .br_recovery_i    (br),
        .rs_full_o        (full),
        .rs2fu_vld_o      (vld),
        .rs2fu_opa_tag_o  (o_opa),
        .rs2fu_opb_tag_o  (o_opb),
        .rs2fu_dest_tag_o (o_dest),
        .rs2fu_IR_o       (o_ir),
        .rs2fu_sel_o      (o_sel),
        .rs2fu_rob_idx_o  (o_rob),
        .rs2fu_NPC_o      (o_npc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id2rs_vld = 1'b0;
        cdb_vld   = 1'b0;
        br        = 1'b0;
    endtask

    // Advance one clock, sample point #1 after the edge, inputs back to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drive(input fu_sel_e s, input logic [PRF_IDX_W-1:0] a, input logic [PRF_IDX_W-1:0] b,
                         input logic ardy, input logic brdy, input logic [PRF_IDX_W-1:0] d);
        id2rs_vld = 1'b1;
        sel       = s;
        opa_tag   = a;
        opb_tag   = b;
        opa_rdy   = ardy;
        opb_rdy   = brdy;
        dest_tag  = d;
        ir        = 32'hA000_0000 | 32'(d);
        rob       = ROB_IDX_W'(d);
        npc       = 64'h4000 + 64'(d);
    endtask

    task automatic cdb(input logic [PRF_IDX_W-1:0] t);
        cdb_vld = 1'b1;
        cdb_tag = t;
    endtask

    task automatic expect_issue(input string name, input fu_sel_e s, input logic [PRF_IDX_W-1:0] a,
                                input logic [PRF_IDX_W-1:0] b, input logic [PRF_IDX_W-1:0] d);
        chk({name, "_vld"},  64'(vld),    64'd1);
        chk({name, "_sel"},  64'(o_sel),  64'(s));
        chk({name, "_opa"},  64'(o_opa),  64'(a));
        chk({name, "_opb"},  64'(o_opb),  64'(b));
        chk({name, "_dest"}, 64'(o_dest), 64'(d));
        chk({name, "_rob"},  64'(o_rob),  64'(d[ROB_IDX_W-1:0]));
        chk({name, "_ir"},   64'(o_ir),   64'h0000_0000_A000_0000 | 64'(d));
        chk({name, "_npc"},  o_npc,       64'h4000 + 64'(d));
    endtask

    task automatic expect_none(input string name);
        chk({name, "_vld"}, 64'(vld),   64'd0);
        chk({name, "_sel"}, 64'(o_sel), 64'(FU_SEL_NONE));
    endtask

    task automatic flush();
        br = 1'b1;
        step();
        repeat (MULT_LAT + 1) step();
    endtask

    initial begin
        vecs[0] = '{FU_SEL_ALU,   6'd5,  6'd6,  1'b1, 1'b1, 6'd10, 1'b0, 6'd0,  1'b1, FU_SEL_ALU};
        vecs[1] = '{FU_SEL_ALU,   6'd9,  6'd6,  1'b0, 1'b1, 6'd11, 1'b1, 6'd9,  1'b1, FU_SEL_ALU};
        vecs[2] = '{FU_SEL_ALU,   6'd9,  6'd6,  1'b0, 1'b1, 6'd12, 1'b0, 6'd0,  1'b0, FU_SEL_NONE};
        vecs[3] = '{FU_SEL_MULT,  6'd0,  6'd7,  1'b0, 1'b1, 6'd13, 1'b0, 6'd0,  1'b1, FU_SEL_MULT};
        vecs[4] = '{FU_SEL_NONE,  6'd5,  6'd6,  1'b1, 1'b1, 6'd14, 1'b0, 6'd0,  1'b0, FU_SEL_NONE};
        vecs[5] = '{FU_SEL_BR,    6'd3,  6'd12, 1'b1, 1'b0, 6'd15, 1'b1, 6'd12, 1'b1, FU_SEL_BR};
        vecs[6] = '{FU_SEL_LOAD,  6'd3,  6'd12, 1'b1, 1'b0, 6'd16, 1'b1, 6'd13, 1'b0, FU_SEL_NONE};
        vecs[7] = '{FU_SEL_STORE, 6'd17, 6'd18, 1'b1, 1'b1, 6'd19, 1'b0, 6'd0,  1'b1, FU_SEL_STORE};

        sel = '0; opa_tag = '0; opb_tag = '0; opa_rdy = 1'b0; opb_rdy = 1'b0;
        dest_tag = '0; ir = '0; rob = '0; npc = '0; cdb_tag = '0;
        idle();

        // Reset state.
        rst = 1'b1;
        step();
        step();
        expect_none("rst");
        chk("rst_opa",  64'(o_opa),  64'(ZERO_REG));
        chk("rst_opb",  64'(o_opb),  64'(ZERO_REG));
        chk("rst_dest", 64'(o_dest), 64'(ZERO_REG));
        chk("rst_ir",   64'(o_ir),   64'd0);
        chk("rst_rob",  64'(o_rob),  64'd0);
        chk("rst_npc",  o_npc,       64'd0);
        chk("rst_full", 64'(full),   64'd0);
        rst = 1'b0;
        step();

        // Table: dispatch at cycle 0, issue (or not) visible at cycle 2.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].sel, vecs[i].opa, vecs[i].opb, vecs[i].ardy, vecs[i].brdy, vecs[i].dest);
            if (vecs[i].cvld) cdb(vecs[i].ctag);
            step();
            step();
            if (vecs[i].exp_vld)
                expect_issue($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].opa, vecs[i].opb, vecs[i].dest);
            else
                expect_none($sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d_freed", i), 64'(vld), 64'd0);
            flush();
        end

        // Late CDB wakeup: broadcast at cycle 3, issue at cycle 5.
        drive(FU_SEL_ALU, 6'd9, 6'd6, 1'b0, 1'b1, 6'd20);
        for (int c = 1; c <= 4; c++) begin
            step();
            expect_none($sformatf("wake_c%0d", c));
            if (c == 3) cdb(6'd9);
        end
        step();
        expect_issue("wake_c5", FU_SEL_ALU, 6'd9, 6'd6, 6'd20);
        flush();

        // Fill all entries, drop a dispatch while full, wake entry 3.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_full%0d", i), 64'(full), 64'd0);
            drive(FU_SEL_ALU, PRF_IDX_W'(20 + i), 6'd6, 1'b0, 1'b1, PRF_IDX_W'(40 + i));
            step();
        end
        chk("full_set", 64'(full), 64'd1);
        drive(FU_SEL_ALU, 6'd5, 6'd6, 1'b1, 1'b1, 6'd63);
        step();
        chk("full_c9", 64'(full), 64'd1);
        expect_none("full_c9");
        cdb(6'd23);
        step();
        chk("full_c10", 64'(full), 64'd1);
        expect_none("full_c10");
        step();
        chk("full_c11", 64'(full), 64'd0);
        expect_issue("full_wake3", FU_SEL_ALU, 6'd23, 6'd6, 6'd43);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("full_after%0d", c), 64'(vld), 64'd0);
        end
        flush();

        // Collision slot: MULT selected c1, ALU eligible c4 is held to c5.
        drive(FU_SEL_MULT, 6'd5, 6'd6, 1'b1, 1'b1, 6'd30);
        step();
        step();
        expect_issue("coll_mult", FU_SEL_MULT, 6'd5, 6'd6, 6'd30);
        step();
        drive(FU_SEL_ALU, 6'd5, 6'd6, 1'b1, 1'b1, 6'd31);
        step();
        expect_none("coll_c4");
        step();
        expect_none("coll_c5");
        step();
        expect_issue("coll_alu", FU_SEL_ALU, 6'd5, 6'd6, 6'd31);
        flush();

        // Blocked ALU in entry 0 must not starve a BR in entry 1.
        drive(FU_SEL_ALU, 6'd30, 6'd6, 1'b0, 1'b1, 6'd32);
        step();
        drive(FU_SEL_MULT, 6'd5, 6'd6, 1'b1, 1'b1, 6'd33);
        step();
        step();
        expect_issue("pri_mult", FU_SEL_MULT, 6'd5, 6'd6, 6'd33);
        step();
        drive(FU_SEL_BR, 6'd5, 6'd6, 1'b1, 1'b1, 6'd34);
        cdb(6'd30);
        step();
        expect_none("pri_c5");
        step();
        expect_issue("pri_br", FU_SEL_BR, 6'd5, 6'd6, 6'd34);
        step();
        expect_issue("pri_alu", FU_SEL_ALU, 6'd30, 6'd6, 6'd32);
        flush();

        // Branch recovery with 5 waiting entries and a multiply in flight.
        for (int i = 0; i < 5; i++) begin
            drive(FU_SEL_ALU, PRF_IDX_W'(40 + i), 6'd6, 1'b0, 1'b1, PRF_IDX_W'(50 + i));
            step();
        end
        drive(FU_SEL_MULT, 6'd5, 6'd6, 1'b1, 1'b1, 6'd56);
        step();
        cdb(6'd40);
        step();
        expect_issue("br_mult", FU_SEL_MULT, 6'd5, 6'd6, 6'd56);
        br = 1'b1;
        drive(FU_SEL_ALU, 6'd5, 6'd6, 1'b1, 1'b1, 6'd57);
        step();
        expect_none("br_c8");
        chk("br_full", 64'(full), 64'd0);
        drive(FU_SEL_ALU, 6'd5, 6'd6, 1'b1, 1'b1, 6'd58);
        step();
        expect_none("br_c9");
        step();
        expect_none("br_c10");
        step();
        expect_issue("br_alu", FU_SEL_ALU, 6'd5, 6'd6, 6'd58);
        cdb(6'd41);
        step();
        expect_none("br_c12");
        step();
        expect_none("br_c13");
        flush();

        // Reset (with recovery) while issuing.
        drive(FU_SEL_ALU, 6'd5, 6'd6, 1'b1, 1'b1, 6'd60);
        step();
        drive(FU_SEL_ALU, 6'd5, 6'd6, 1'b1, 1'b1, 6'd61);
        step();
        expect_issue("mid_pre", FU_SEL_ALU, 6'd5, 6'd6, 6'd60);
        rst = 1'b1;
        br  = 1'b1;
        step();
        expect_none("mid_rst");
        chk("mid_opa",  64'(o_opa),  64'(ZERO_REG));
        chk("mid_opb",  64'(o_opb),  64'(ZERO_REG));
        chk("mid_dest", 64'(o_dest), 64'(ZERO_REG));
        chk("mid_ir",   64'(o_ir),   64'd0);
        chk("mid_rob",  64'(o_rob),  64'd0);
        chk("mid_npc",  o_npc,       64'd0);
        chk("mid_full", 64'(full),   64'd0);
        rst = 1'b0;
        step();
        expect_none("mid_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
